// File: rtl/control_unit.sv
// RV32I main decoder plus ALU decoder for load, store, OP-IMM and OP instructions.
// All control strobes are registered, giving one cycle from field inputs to outputs.

package rv32i_pkg;
  typedef logic [6:0] instr_type_t;
  typedef logic [2:0] func_code_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam instr_type_t OPC_LOAD   = 7'd3;
  localparam instr_type_t OPC_OP_IMM = 7'd19;
  localparam instr_type_t OPC_STORE  = 7'd35;
  localparam instr_type_t OPC_OP     = 7'd51;
endpackage

module control_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  instr_type_t instr_type,
  input  func_code_t  func_code,
  input  logic        funct7b5,
  output logic        resultsrc,
  output logic        memwrite,
  output logic        alusrc,
  output logic        immsrc,
  output logic        regwrite,
  output alu_op_t     alu_ctrl,
  output logic        illegal
);

  logic    resultsrc_d;
  logic    memwrite_d;
  logic    alusrc_d;
  logic    immsrc_d;
  logic    regwrite_d;
  alu_op_t alu_ctrl_d;
  logic    illegal_d;
  alu_op_t alu_funct3;

  // Shared funct3 map; the only funct7b5-dependent entry common to both
  // ALU classes is the arithmetic/logical right shift.
  always_comb begin
    alu_funct3 = ALU_ADD;
    case (func_code)
      3'd0: alu_funct3 = ALU_ADD;
      3'd1: alu_funct3 = ALU_SLL;
      3'd2: alu_funct3 = ALU_SLT;
      3'd3: alu_funct3 = ALU_SLTU;
      3'd4: alu_funct3 = ALU_XOR;
      3'd5: alu_funct3 = funct7b5 ? ALU_SRA : ALU_SRL;
      3'd6: alu_funct3 = ALU_OR;
      3'd7: alu_funct3 = ALU_AND;
      default: alu_funct3 = ALU_ADD;
    endcase
  end

  always_comb begin
    resultsrc_d = 1'b0;
    memwrite_d  = 1'b0;
    alusrc_d    = 1'b0;
    immsrc_d    = 1'b0;
    regwrite_d  = 1'b0;
    alu_ctrl_d  = ALU_ADD;
    illegal_d   = 1'b0;
    case (instr_type)
      OPC_LOAD: begin
        resultsrc_d = 1'b1;
        alusrc_d    = 1'b1;
        regwrite_d  = 1'b1;
      end
      OPC_STORE: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        immsrc_d   = 1'b1;
      end
      OPC_OP_IMM: begin
        alusrc_d   = 1'b1;
        regwrite_d = 1'b1;
        alu_ctrl_d = alu_funct3;
      end
      OPC_OP: begin
        // funct7b5 is only meaningful for SUB and SRA; anything else is rejected
        // as a no-write decode.
        if (funct7b5 && (func_code != 3'd0) && (func_code != 3'd5)) begin
          illegal_d = 1'b1;
        end else begin
          regwrite_d = 1'b1;
          alu_ctrl_d = (func_code == 3'd0 && funct7b5) ? ALU_SUB : alu_funct3;
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultsrc <= 1'b0;
      memwrite  <= 1'b0;
      alusrc    <= 1'b0;
      immsrc    <= 1'b0;
      regwrite  <= 1'b0;
      alu_ctrl  <= ALU_ADD;
      illegal   <= 1'b0;
    end else begin
      resultsrc <= resultsrc_d;
      memwrite  <= memwrite_d;
      alusrc    <= alusrc_d;
      immsrc    <= immsrc_d;
      regwrite  <= regwrite_d;
      alu_ctrl  <= alu_ctrl_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed decode scenarios plus a randomized
// sequence checked against a table-driven reference model of the previous cycle.

module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] instr_type;
  logic [2:0] func_code;
  logic       funct7b5;
  logic       resultsrc;
  logic       memwrite;
  logic       alusrc;
  logic       immsrc;
  logic       regwrite;
  logic [3:0] alu_ctrl;
  logic       illegal;

  int checks;
  int failures;

  // {resultsrc, memwrite, alusrc, immsrc, regwrite, alu_ctrl[3:0], illegal}
  logic [9:0] outs;
  assign outs = {resultsrc, memwrite, alusrc, immsrc, regwrite, alu_ctrl, illegal};

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .instr_type (instr_type),
    .func_code  (func_code),
    .funct7b5   (funct7b5),
    .resultsrc  (resultsrc),
    .memwrite   (memwrite),
    .alusrc     (alusrc),
    .immsrc     (immsrc),
    .regwrite   (regwrite),
    .alu_ctrl   (alu_ctrl),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: instruction class decides the strobes, funct3 indexes an op table.
  function automatic logic [9:0] model(input int op, input int f3, input int b5);
    int alu_map [8];
    int alu;
    alu_map = '{0, 2, 3, 4, 5, 6, 8, 9};
    alu = alu_map[f3];
    if (f3 == 5 && b5 == 1) alu = 7;
    case (op)
      3:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
      35: return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
      19: return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, alu[3:0], 1'b0};
      51: begin
        if (b5 == 1 && f3 != 0 && f3 != 5) return {9'd0, 1'b1};
        if (b5 == 1 && f3 == 0) alu = 1;
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, alu[3:0], 1'b0};
      end
      default: return {9'd0, 1'b1};
    endcase
  endfunction

  // Drive fields 1 time unit after an edge, then sample 1 unit after the next edge.
  task automatic apply(input int op, input int f3, input int b5);
    instr_type = op[6:0];
    func_code  = f3[2:0];
    funct7b5   = b5[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    instr_type = 7'd35; func_code = 3'd2; funct7b5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold: outs=%b expected=%b", outs, 10'd0);
    end
    rst = 1'b0;
    apply(35, 2, 0);
    checks++;
    if (outs !== 10'b0_1_1_1_0_0000_0) begin
      failures++;
      $display("FAIL reset_store_before: outs=%b expected=%b", outs, 10'b0_1_1_1_0_0000_0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== 10'd0) begin
      failures++;
      $display("FAIL reset_async: outs=%b expected=%b", outs, 10'd0);
    end
    apply(3, 0, 0);
    apply(3, 0, 0);
    checks++;
    if (outs !== 10'd0) begin
      failures++;
      $display("FAIL reset_held_edges: outs=%b expected=%b", outs, 10'd0);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (outs !== 10'b1_0_1_0_1_0000_0) begin
      failures++;
      $display("FAIL reset_first_decode: outs=%b expected=%b", outs, 10'b1_0_1_0_1_0000_0);
    end
  endtask

  task automatic test_load_store;
    apply(3, 2, 0);
    checks++;
    if (outs !== 10'b1_0_1_0_1_0000_0) begin
      failures++;
      $display("FAIL load: outs=%b expected=%b", outs, 10'b1_0_1_0_1_0000_0);
    end
    apply(35, 2, 1);
    checks++;
    if (outs !== 10'b0_1_1_1_0_0000_0) begin
      failures++;
      $display("FAIL store: outs=%b expected=%b", outs, 10'b0_1_1_1_0_0000_0);
    end
  endtask

  task automatic test_rtype;
    int f3s [8];
    int b5s [8];
    int alus [8];
    f3s  = '{0, 0, 1, 4, 5, 6, 7, 5};
    b5s  = '{1, 0, 0, 0, 0, 0, 0, 1};
    alus = '{1, 0, 2, 5, 6, 8, 9, 7};
    for (int i = 0; i < 8; i++) begin
      apply(51, f3s[i], b5s[i]);
      checks++;
      if (outs !== {5'b0_0_0_0_1, alus[i][3:0], 1'b0}) begin
        failures++;
        $display("FAIL rtype f3=%0d b5=%0d: outs=%b expected=%b", f3s[i], b5s[i], outs,
                 {5'b0_0_0_0_1, alus[i][3:0], 1'b0});
      end
    end
  endtask

  task automatic test_itype;
    apply(19, 0, 1);
    checks++;
    if (outs !== 10'b0_0_1_0_1_0000_0) begin
      failures++;
      $display("FAIL itype_addi_b5: outs=%b expected=%b", outs, 10'b0_0_1_0_1_0000_0);
    end
    apply(19, 5, 1);
    checks++;
    if (outs !== 10'b0_0_1_0_1_0111_0) begin
      failures++;
      $display("FAIL itype_srai: outs=%b expected=%b", outs, 10'b0_0_1_0_1_0111_0);
    end
  endtask

  task automatic test_illegal;
    apply(99, 0, 0);
    checks++;
    if (outs !== 10'b0_0_0_0_0_0000_1) begin
      failures++;
      $display("FAIL illegal_opcode: outs=%b expected=%b", outs, 10'b0_0_0_0_0_0000_1);
    end
    apply(51, 4, 1);
    checks++;
    if (outs !== 10'b0_0_0_0_0_0000_1) begin
      failures++;
      $display("FAIL illegal_rtype: outs=%b expected=%b", outs, 10'b0_0_0_0_0_0000_1);
    end
    apply(3, 0, 0);
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clears: illegal=%b expected=0", illegal);
    end
  endtask

  task automatic test_random;
    int ops [4];
    int f3s [6];
    logic [9:0] exp_q [$];
    logic [9:0] exp;
    int op, f3, b5;
    ops = '{3, 19, 35, 51};
    f3s = '{0, 1, 4, 5, 6, 7};
    for (int i = 0; i < 1000; i++) begin
      op = ops[$urandom_range(0, 3)];
      f3 = f3s[$urandom_range(0, 5)];
      b5 = int'($urandom_range(0, 1));
      exp_q.push_back(model(op, f3, b5));
      apply(op, f3, b5);
      exp = exp_q.pop_front();
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL random cycle=%0d op=%0d f3=%0d b5=%0d: outs=%b expected=%b",
                 i, op, f3, b5, outs, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_store();
    test_rtype();
    test_itype();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder plus ALU decoder for the RV32I core. Supports four opcode classes: load, I-type ALU, store and R-type ALU.
- Maps opcode, funct3 and funct7 bit 5 to datapath control strobes and an ALU operation code.
- Outputs are registered: one pipeline stage between the fetch/decode field inputs and the execute datapath.

Parameters:
- None. Widths are fixed by rv32i_pkg: instr_type_t is 7 bits, func_code_t is 3 bits, alu_op_t is 4 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_type  in  7  opcode field (instr_type_t): 3=LOAD, 19=OP_IMM, 35=STORE, 51=OP
- func_code  in  3  funct3 (func_code_t)
- funct7b5  in  1  instruction bit 30
- resultsrc  out  1  writeback select: 1=memory read data, 0=ALU result
- memwrite  out  1  data-memory write enable
- alusrc  out  1  ALU B select: 1=immediate, 0=rs2
- immsrc  out  1  immediate format: 0=I-type, 1=S-type
- regwrite  out  1  register-file write enable
- alu_ctrl  out  4  ALU operation (alu_op_t)
- illegal  out  1  unsupported encoding decoded

Behaviour:
- alu_op_t encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9. Codes 10-15 are never driven.
- Decoding is combinational from the inputs. All outputs are flopped on the rising clk edge. Latency is exactly 1 cycle: values sampled at edge N appear after edge N and hold until edge N+1.
- rst asserted, at any time and independent of clk: all outputs go to 0 immediately (alu_ctrl=ADD, illegal=0). Outputs stay 0 while rst is high. The first decode occurs at the first rising edge after rst deasserts.
- LOAD (3): resultsrc=1, memwrite=0, alusrc=1, immsrc=0, regwrite=1, alu_ctrl=ADD. funct3 and funct7b5 are ignored.
- STORE (35): resultsrc=0, memwrite=1, alusrc=1, immsrc=1, regwrite=0, alu_ctrl=ADD. funct3 and funct7b5 are ignored.
- OP_IMM (19): resultsrc=0, memwrite=0, alusrc=1, immsrc=0, regwrite=1. alu_ctrl from funct3 as follows:
  - 0 -> ADD; funct7b5 is ignored, so there is no SUBI.
  - 1 -> SLL
  - 2 -> SLT
  - 3 -> SLTU
  - 4 -> XOR
  - 5 -> SRA if funct7b5=1, else SRL
  - 6 -> OR
  - 7 -> AND
- OP (51): resultsrc=0, memwrite=0, alusrc=0, immsrc=0, regwrite=1. alu_ctrl uses the same funct3 map, except funct3=0 with funct7b5=1 gives SUB.
- Illegal R-type: OP with funct7b5=1 and funct3 not in {0,5}. Drives illegal=1, regwrite=0, memwrite=0, alu_ctrl=ADD, and the other strobes 0.
- Any other opcode value: illegal=1 and all other outputs 0 (alu_ctrl=ADD). This is a safe no-write decode.
- For every legal decode, illegal=0.
- X or Z on inputs is not required to propagate. Use a default case so that no latches are inferred.

Test Plan:
- Reset: assert rst mid-cycle while outputs show a STORE decode -> all outputs 0 immediately, before the next clk edge; they remain 0 until the first edge after deassert.
- Load then store: edge with instr_type=3, func_code=2 -> next cycle resultsrc=1, alusrc=1, regwrite=1, memwrite=0, immsrc=0, alu_ctrl=0. Then instr_type=35, func_code=2 -> memwrite=1, immsrc=1, regwrite=0, alu_ctrl=0.
- R-type sweep with instr_type=51:
  - func_code=0, funct7b5=1 -> alu_ctrl=1 (SUB), alusrc=0, regwrite=1.
  - func_code=0, funct7b5=0 -> alu_ctrl=0.
  - func_code 1/4/5/6/7 with funct7b5=0 -> alu_ctrl 2/5/6/8/9.
  - func_code=5, funct7b5=1 -> alu_ctrl=7.
- I-type: instr_type=19, func_code=0, funct7b5=1 -> alu_ctrl=0 (ADD, not SUB), alusrc=1. func_code=5, funct7b5=1 -> alu_ctrl=7.
- Illegal: instr_type=99 -> illegal=1, regwrite=0, memwrite=0. instr_type=51, func_code=4, funct7b5=1 -> illegal=1, regwrite=0.
- Latency: randomized opcode from {3,19,35,51}, func_code from {0,1,4,5,6,7}, funct7b5 from {0,1} for 1000 cycles -> outputs match a reference model of the previous cycle's inputs every cycle.
